// File: rtl/nibble_add_pkg.sv
// Shared types for the nibble-serial adder.
// Nibble width and sequencer state encoding.
package nibble_add_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/ripple_carry.sv
// 4-bit ripple-carry adder slice.
// Purely combinational; carry chains bit 0 to bit 3.
import nibble_add_pkg::*;

module ripple_carry (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision add/sub sequencer: one nibble per cycle, LSB first,
// through a single ripple_carry slice, valid/ready on both sides.
import nibble_add_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                c_nib;

  assign in_ready = (state == IDLE);
  assign a_nib    = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign b_nib    = b_q[idx*NIBBLE_W +: NIBBLE_W];

  ripple_carry u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry <= c_nib;
          if (idx == LAST) begin
            // MSB of the result is the top bit of this final nibble
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
            cout      <= c_nib;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=16).
// Each task checks its own scenario against hand-computed values.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Drive one op from a negedge; return captured result and latency.
  // With out_ready high it also waits out the handshake and ends on a negedge.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs,
                        output logic [15:0] rs, output logic rc,
                        output logic ro, output int lat);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    rs = sum; rc = cout; ro = overflow;
    if (out_ready && lat > 0) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 ||
        overflow !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: ov=%b sum=%h c=%b o=%b rdy=%b want 0 0000 0 0 1",
               out_valid, sum, cout, overflow, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add(input string nm, input logic [15:0] va,
                          input logic [15:0] vb, input logic vc,
                          input logic vs, input logic [15:0] es,
                          input logic ec, input logic eo);
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    run_op(va, vb, vc, vs, rs, rc, ro, lat);
    total++;
    if (rs !== es || rc !== ec || ro !== eo || lat !== 4) begin
      bad++;
      $display("FAIL %s: sum=%h c=%b o=%b lat=%0d want %h %b %b 4",
               nm, rs, rc, ro, lat, es, ec, eo);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: rdy=%b ov=%b want 1 0", nm, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    out_ready = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, rs, rc, ro, lat);
    total++;
    if (rs !== 16'h3333 || lat !== 4) begin
      bad++;
      $display("FAIL bp_result: sum=%h lat=%0d want 3333 4", rs, lat);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || sum !== 16'h3333 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: ov=%b sum=%h rdy=%b want 1 3333 0",
                 i, out_valid, sum, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h3333) begin
      bad++;
      $display("FAIL bp_release: ov=%b rdy=%b sum=%h want 0 1 3333",
               out_valid, in_ready, sum);
    end
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_noqueue: ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || in_ready !== 1'b1 || cout !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: ov=%b sum=%h rdy=%b c=%b want 0 0000 1 0",
               out_valid, sum, in_ready, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_nopulse: ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    test_add("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_add("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_add("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_add("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_add("add_cin",   16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    test_add("sub_cin_x", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_backpressure;
    test_reset_mid_run;
    test_add("post_rst",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
